// File: rtl/data_mem_lsu.sv
// Load/store unit between the core's memory stage and a simple request/grant
// data bus. It takes one byte, half or word access per transaction, builds
// the byte-lane strobes and replicated store data, and extracts and extends
// load results. It holds the core with stall and ends a silent bus with a
// timeout.
module data_mem_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic        d_wr_en,
    output logic        stall,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] ST_SB  = 3'b001;
    localparam logic [2:0] ST_SH  = 3'b010;
    localparam logic [2:0] ST_SW  = 3'b100;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LW  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        we_q;
    logic [2:0]  load_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        bus_err_q;

    logic        is_store;
    logic        is_load;
    logic        access;
    logic        misaligned;
    logic        start;
    logic        timeout;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    assign is_store = d_wr_en && (store_type != 3'b000);
    assign is_load  = (load_type != 3'b000);
    assign access   = is_store || is_load;

    // Alignment check; a store wins over a load presented in the same cycle.
    always_comb begin
        misaligned = 1'b0;
        if (is_store) begin
            case (store_type)
                ST_SH:   misaligned = addr[0];
                ST_SW:   misaligned = (addr[1:0] != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end else begin
            case (load_type)
                LD_LH, LD_LHU: misaligned = addr[0];
                LD_LW:         misaligned = (addr[1:0] != 2'b00);
                default:       misaligned = 1'b0;
            endcase
        end
    end

    // The cycle that reports a timeout behaves like DONE: the core is released
    // and the inputs it still presents that cycle are not taken as a new access.
    assign start   = (state == IDLE) && access && !misaligned && !bus_err_q;
    assign timeout = (cnt == 8'hFF) &&
                     (((state == REQ) && !bus_gnt) || ((state == WAIT) && !bus_rvalid));

    // Byte-lane strobes and lane-replicated data for the store being accepted.
    always_comb begin
        strb_next  = 4'b0000;
        wdata_next = wdata;
        case (store_type)
            ST_SB: begin
                strb_next  = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            ST_SH: begin
                strb_next  = 4'b0011 << {addr[1], 1'b0};
                wdata_next = {2{wdata[15:0]}};
            end
            ST_SW: begin
                strb_next  = 4'b1111;
                wdata_next = wdata;
            end
            default: begin
                strb_next  = 4'b0000;
                wdata_next = wdata;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        sel_byte = bus_rdata[7:0];
        case (off_q)
            2'd0:    sel_byte = bus_rdata[7:0];
            2'd1:    sel_byte = bus_rdata[15:8];
            2'd2:    sel_byte = bus_rdata[23:16];
            default: sel_byte = bus_rdata[31:24];
        endcase
        sel_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (load_q)
            LD_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            LD_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            LD_LW:   load_ext = bus_rdata;
            LD_LBU:  load_ext = {24'h000000, sel_byte};
            LD_LHU:  load_ext = {16'h0000, sel_half};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                if (bus_gnt)      state_next = we_q ? DONE : WAIT;
                else if (timeout) state_next = IDLE;
            end
            WAIT: begin
                if (bus_rvalid)   state_next = DONE;
                else if (timeout) state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Transaction registers, timeout counter and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 8'h00;
            we_q      <= 1'b0;
            load_q    <= 3'b000;
            off_q     <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'b0000;
            rdata_out <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= 8'h00;
                        we_q    <= is_store;
                        load_q  <= is_store ? 3'b000 : load_type;
                        off_q   <= addr[1:0];
                        addr_q  <= {addr[31:2], 2'b00};
                        wdata_q <= is_store ? wdata_next : 32'h0;
                        wstrb_q <= is_store ? strb_next : 4'b0000;
                    end
                end
                REQ: begin
                    if (bus_gnt) cnt <= 8'h00;
                    else         cnt <= cnt + 8'd1;
                end
                WAIT: begin
                    if (bus_rvalid) rdata_out <= load_ext;
                    else            cnt <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign stall       = start || (state == REQ) || (state == WAIT);
    assign bus_req     = (state == REQ);
    assign bus_we      = (state == REQ) && we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_wstrb   = (state == REQ) ? wstrb_q : 4'b0000;
    assign rdata_valid = (state == DONE) && !we_q;
    assign misalign    = (state == IDLE) && access && misaligned && !bus_err_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed testbench for data_mem_lsu: stores, loads, misalignment, timeout
// and reset during a transaction, with hand-computed expected values.
module tb_data_mem_lsu;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  store_type;
    logic [2:0]  load_type;
    logic        d_wr_en;
    logic        stall;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    data_mem_lsu dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .store_type  (store_type),
        .load_type   (load_type),
        .d_wr_en     (d_wr_en),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case a bus handshake never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Runs one store through the bus, granting in the gnt_delay-th REQ cycle.
    task automatic run_store(input logic [2:0] st, input logic [31:0] a, input logic [31:0] wd,
                             input int gnt_delay, output logic [31:0] o_addr,
                             output logic [31:0] o_wdata, output logic [3:0] o_wstrb,
                             output logic o_we, output int stall_cycles,
                             output int valid_pulses, output int unstable);
        @(negedge clk);
        store_type = st; addr = a; wdata = wd; d_wr_en = 1'b1; load_type = 3'b000;
        #1;
        stall_cycles = (stall === 1'b1) ? 1 : 0;
        valid_pulses = (rdata_valid === 1'b1) ? 1 : 0;
        unstable = 0;
        o_addr = 32'h0; o_wdata = 32'h0; o_wstrb = 4'h0; o_we = 1'b0;
        for (int k = 0; k < gnt_delay; k++) begin
            @(negedge clk);
            if (stall === 1'b1) stall_cycles++;
            if (rdata_valid === 1'b1) valid_pulses++;
            if (bus_req !== 1'b1) unstable++;
            if (k == 0) begin
                o_addr = bus_addr; o_wdata = bus_wdata; o_wstrb = bus_wstrb; o_we = bus_we;
            end else if (bus_addr !== o_addr || bus_wdata !== o_wdata ||
                         bus_wstrb !== o_wstrb || bus_we !== o_we) begin
                unstable++;
            end
            if (k == gnt_delay - 1) bus_gnt = 1'b1;
        end
        @(negedge clk);
        bus_gnt = 1'b0;
        if (stall === 1'b1) stall_cycles++;
        if (rdata_valid === 1'b1) valid_pulses++;
        d_wr_en = 1'b0; store_type = 3'b000;
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        if (rdata_valid === 1'b1) valid_pulses++;
    endtask

    // Runs one load: grant in the first REQ cycle, data in the first WAIT cycle.
    task automatic run_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] word,
                            output logic [31:0] result, output logic [31:0] o_addr,
                            output logic [3:0] o_wstrb, output logic o_we,
                            output int stall_cycles, output int valid_pulses);
        @(negedge clk);
        load_type = lt; addr = a; d_wr_en = 1'b0; store_type = 3'b000;
        #1;
        stall_cycles = (stall === 1'b1) ? 1 : 0;
        valid_pulses = (rdata_valid === 1'b1) ? 1 : 0;
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        o_addr = bus_addr; o_wstrb = bus_wstrb; o_we = bus_we;
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        if (stall === 1'b1) stall_cycles++;
        bus_rvalid = 1'b1; bus_rdata = word;
        @(negedge clk);
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        if (stall === 1'b1) stall_cycles++;
        if (rdata_valid === 1'b1) valid_pulses++;
        result = rdata_out;
        load_type = 3'b000;
        @(negedge clk);
        if (rdata_valid === 1'b1) valid_pulses++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, rdata_valid, misalign, bus_err, bus_req, bus_we} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {stall, rdata_valid, misalign, bus_err, bus_req, bus_we});
        end
        checks++;
        if (rdata_out !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: rdata_out=%h bus_addr=%h bus_wdata=%h wstrb=%b expected all zero",
                     rdata_out, bus_addr, bus_wdata, bus_wstrb);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_byte();
        logic [31:0] a, d; logic [3:0] s; logic we; int st, vp, un;
        run_store(3'b001, 32'h0000_0103, 32'h0000_00AB, 2, a, d, s, we, st, vp, un);
        checks++;
        if (a !== 32'h100 || s !== 4'b1000 || d !== 32'hABABABAB || we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_bus: addr=%h wstrb=%b wdata=%h we=%b expected 00000100 1000 abababab 1", a, s, d, we);
        end
        checks++;
        if (st != 3 || vp != 0 || un != 0) begin
            errors++;
            $display("[TB] FAIL sb_timing: stall_cycles=%0d valid=%0d unstable=%0d expected 3 0 0", st, vp, un);
        end
    endtask

    task automatic test_store_half_word();
        logic [31:0] a, d; logic [3:0] s; logic we; int st, vp, un;
        run_store(3'b010, 32'h0000_0102, 32'h1234_ABCD, 1, a, d, s, we, st, vp, un);
        checks++;
        if (a !== 32'h100 || s !== 4'b1100 || d !== 32'hABCDABCD || st != 2 || un != 0) begin
            errors++;
            $display("[TB] FAIL sh_bus: addr=%h wstrb=%b wdata=%h stall=%0d expected 00000100 1100 abcdabcd 2", a, s, d, st);
        end
        run_store(3'b100, 32'h0000_0104, 32'hDEAD_BEEF, 3, a, d, s, we, st, vp, un);
        checks++;
        if (a !== 32'h104 || s !== 4'b1111 || d !== 32'hDEADBEEF || st != 4 || un != 0 || vp != 0) begin
            errors++;
            $display("[TB] FAIL sw_bus: addr=%h wstrb=%b wdata=%h stall=%0d expected 00000104 1111 deadbeef 4", a, s, d, st);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] r, a; logic [3:0] s; logic we; int st, vp;
        run_load(3'b001, 32'h0000_0102, 32'h12F4_5678, r, a, s, we, st, vp);
        checks++;
        if (r !== 32'hFFFFFFF4 || vp != 1 || st != 3) begin
            errors++;
            $display("[TB] FAIL lb: rdata=%h valid=%0d stall=%0d expected fffffff4 1 3", r, vp, st);
        end
        checks++;
        if (a !== 32'h100 || s !== 4'b0000 || we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lb_bus: addr=%h wstrb=%b we=%b expected 00000100 0000 0", a, s, we);
        end
        run_load(3'b100, 32'h0000_0102, 32'h12F4_5678, r, a, s, we, st, vp);
        checks++;
        if (r !== 32'h000000F4 || vp != 1) begin
            errors++;
            $display("[TB] FAIL lbu: rdata=%h valid=%0d expected 000000f4 1", r, vp);
        end
        run_load(3'b001, 32'h0000_0101, 32'h12F4_5678, r, a, s, we, st, vp);
        checks++;
        if (r !== 32'h00000056) begin
            errors++;
            $display("[TB] FAIL lb_pos: rdata=%h expected 00000056", r);
        end
    endtask

    task automatic test_load_half_word();
        logic [31:0] r, a; logic [3:0] s; logic we; int st, vp;
        run_load(3'b010, 32'h0000_0102, 32'h8001_1234, r, a, s, we, st, vp);
        checks++;
        if (r !== 32'hFFFF8001 || vp != 1) begin
            errors++;
            $display("[TB] FAIL lh: rdata=%h valid=%0d expected ffff8001 1", r, vp);
        end
        run_load(3'b101, 32'h0000_0102, 32'h8001_1234, r, a, s, we, st, vp);
        checks++;
        if (r !== 32'h00008001) begin
            errors++;
            $display("[TB] FAIL lhu: rdata=%h expected 00008001", r);
        end
        run_load(3'b010, 32'h0000_0100, 32'h8001_1234, r, a, s, we, st, vp);
        checks++;
        if (r !== 32'h00001234) begin
            errors++;
            $display("[TB] FAIL lh_low: rdata=%h expected 00001234", r);
        end
        run_load(3'b011, 32'h0000_0100, 32'h8001_1234, r, a, s, we, st, vp);
        checks++;
        if (r !== 32'h80011234 || vp != 1) begin
            errors++;
            $display("[TB] FAIL lw: rdata=%h valid=%0d expected 80011234 1", r, vp);
        end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        d_wr_en = 1'b1; store_type = 3'b100; addr = 32'h0000_0202; wdata = 32'h1111_2222;
        #1;
        checks++;
        if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_misalign: misalign=%b stall=%b bus_req=%b expected 1 0 0", misalign, stall, bus_req);
        end
        @(negedge clk);
        d_wr_en = 1'b0; store_type = 3'b000;
        load_type = 3'b010; addr = 32'h0000_0101;
        #1;
        checks++;
        if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lh_misalign: misalign=%b stall=%b bus_req=%b expected 1 0 0", misalign, stall, bus_req);
        end
        @(negedge clk);
        load_type = 3'b000;
        #1;
        checks++;
        if (misalign !== 1'b0 || bus_req !== 1'b0 || rdata_out !== 32'h80011234) begin
            errors++;
            $display("[TB] FAIL misalign_after: misalign=%b bus_req=%b rdata=%h expected 0 0 80011234",
                     misalign, bus_req, rdata_out);
        end
    endtask

    task automatic test_store_priority();
        @(negedge clk);
        d_wr_en = 1'b0; store_type = 3'b100; addr = 32'h0000_0200;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_wr_en: stall=%b expected 0", stall);
        end
        d_wr_en = 1'b1; store_type = 3'b001; load_type = 3'b011;
        addr = 32'h0000_0101; wdata = 32'h0000_005A;
        #1;
        checks++;
        if (misalign !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_accept: misalign=%b stall=%b expected 0 1", misalign, stall);
        end
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wstrb !== 4'b0010 || bus_wdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("[TB] FAIL prio_store: req=%b we=%b wstrb=%b wdata=%h expected 1 1 0010 5a5a5a5a",
                     bus_req, bus_we, bus_wstrb, bus_wdata);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        checks++;
        if (rdata_valid !== 1'b0 || stall !== 1'b0 || rdata_out !== 32'h80011234) begin
            errors++;
            $display("[TB] FAIL prio_done: valid=%b stall=%b rdata=%h expected 0 0 80011234", rdata_valid, stall, rdata_out);
        end
        d_wr_en = 1'b0; store_type = 3'b000; load_type = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        @(negedge clk);
        load_type = 3'b011; addr = 32'h0000_0300;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        n = 1;
        seen = 1'b0;
        while (n < 400 && !seen) begin
            if (bus_err === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!seen || n < 255 || n > 258) begin
            errors++;
            $display("[TB] FAIL timeout_cycle: bus_err seen=%0d after %0d cycles expected 1 within 255..258", seen, n);
        end
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || rdata_out !== 32'h80011234) begin
            errors++;
            $display("[TB] FAIL timeout_state: stall=%b req=%b rdata=%h expected 0 0 80011234", stall, bus_req, rdata_out);
        end
        load_type = 3'b000;
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: bus_err=%b stall=%b expected 0 0", bus_err, stall);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        load_type = 3'b011; addr = 32'h0000_0100;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        checks++;
        if (stall !== 1'b1 || bus_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_reached: stall=%b req=%b expected 1 0", stall, bus_req);
        end
        reset = 1'b1; load_type = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wait: stall=%b req=%b expected 0 0", stall, bus_req);
        end
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        bus_rvalid = 1'b0;
        checks++;
        if (rdata_valid !== 1'b0 || rdata_out !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_rvalid: valid=%b rdata=%h stall=%b expected 0 00000000 0", rdata_valid, rdata_out, stall);
        end
        @(negedge clk);
        checks++;
        if (rdata_valid !== 1'b0 || rdata_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL late_rvalid_after: valid=%b rdata=%h expected 0 00000000", rdata_valid, rdata_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        addr = 32'h0; wdata = 32'h0; store_type = 3'b000; load_type = 3'b000; d_wr_en = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_store_byte();
        test_store_half_word();
        test_load_byte();
        test_load_half_word();
        test_misalign();
        test_store_priority();
        test_timeout();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 addr  in  32  effective byte address (ALU result).
REQ-005 wdata  in  32  store data (rs2).
REQ-006 store_type  in  3  001=SB, 010=SH, 100=SW, 000=none.
REQ-007 load_type  in  3  001=LB, 010=LH, 011=LW, 100=LBU, 101=LHU, 000=none.
REQ-008 d_wr_en  in  1  store qualifier from decode.
REQ-009 stall  out  1  core must hold PC and inputs while high.
REQ-010 rdata_out  out  32  extended load result.
REQ-011 rdata_valid  out  1  one-cycle pulse when rdata_out is updated.
REQ-012 misalign  out  1  one-cycle pulse on a misaligned access.
REQ-013 bus_err  out  1  one-cycle pulse on bus timeout.
REQ-014 bus_req  out  1  bus request.
REQ-015 bus_we  out  1  1=write.
REQ-016 bus_addr  out  32  word address ({addr[31:2],2'b00}).
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_wstrb  out  4  byte-lane enables; 0000 for reads.
REQ-019 bus_gnt  in  1  request accepted.
REQ-020 bus_rvalid  in  1  read data valid.
REQ-021 bus_rdata  in  32  read word.

Function
REQ-022 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-023 An access SHALL be detected in IDLE when (d_wr_en && store_type!=0) || load_type!=0. A store SHALL take priority if both are present.
REQ-024 A misaligned access SHALL pulse misalign for one cycle, stay in IDLE, leave bus_req low and hold stall low. Misaligned means: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0.
REQ-025 On an aligned access, IDLE SHALL move to REQ and register addr, type, bus_wdata and bus_wstrb.
REQ-026 stall SHALL equal (IDLE && aligned access) || REQ || WAIT. It SHALL be low in DONE.
REQ-027 In REQ, bus_req SHALL be 1 and bus_addr/we/wdata/wstrb SHALL be stable until bus_gnt.
REQ-028 On bus_gnt, REQ SHALL move to DONE for a store or to WAIT for a load.
REQ-029 bus_rvalid SHALL be honoured only in WAIT. On bus_rvalid, rdata_out SHALL be registered and the FSM SHALL move to DONE.
REQ-030 DONE SHALL pulse rdata_valid (loads only) and then return to IDLE unconditionally, without re-sampling inputs that cycle.
REQ-031 Store wstrb: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],1'b0}; SW = 1111.
REQ-032 Store wdata: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-033 Load extraction: the byte is selected by addr[1:0] and the half by addr[1]. LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-034 rdata_out SHALL hold its last value until the next load completes.
REQ-035 An 8-bit counter SHALL clear on entry to REQ and on REQ->WAIT, and SHALL increment in REQ and WAIT.
REQ-036 When the counter reaches 255, the FSM SHALL go to IDLE, pulse bus_err, drop bus_req and drop stall. rdata_out SHALL be unchanged.

Reset
REQ-037 On reset the FSM SHALL go to IDLE and every output SHALL be 0, including rdata_out=0x00000000 and the counter.
REQ-038 A reset asserted mid-transaction SHALL drop bus_req and stall on the next edge. A late bus_rvalid SHALL then be ignored.

Verification
REQ-039 SB, addr=0x103, wdata=0x000000AB, gnt after 2 cycles -> bus_addr=0x100, wstrb=1000, bus_wdata=0xABABABAB, stall high 3 cycles, no rdata_valid.
REQ-040 LB, addr=0x102, bus_rdata=0x12F45678 -> rdata_out=0xFFFFFFF4. The same access with LBU -> 0x000000F4. rdata_valid pulses once in DONE.
REQ-041 LH, addr=0x102, bus_rdata=0x80011234 -> rdata_out=0xFFFF8001. LHU -> 0x00008001. LW, addr=0x100 -> 0x80011234.
REQ-042 SW, addr=0x202 -> misalign pulses 1 cycle, bus_req and stall stay 0. LH, addr=0x101 -> same response.
REQ-043 A load with gnt given but rvalid never asserted -> bus_err pulses at 255 cycles, FSM returns to IDLE and rdata_out is unchanged.
REQ-044 Reset asserted in WAIT, then rvalid delivered -> FSM in IDLE, rdata_valid stays 0, rdata_out=0.
